// File: rtl/receptor_serie_4b.sv
// Serial-to-parallel frame receiver: start bit, 4 data bits LSB first, stop bit.
// Feeds a 4-bit parallel register: Q drives its D and valid drives its enable.
module receptor_serie_4b #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [3:0] Q,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_m;
  logic             rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       sh;

  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset can never look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      Q     <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (en && !rx_s) state <= START;
        end

        // Half a bit in: confirm the start bit is still low, otherwise treat it as a glitch.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            sh  <= {rx_s, sh[3:1]};
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              Q     <= sh;
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_receptor_serie_4b.sv
// Self-checking bench for receptor_serie_4b: a frame-timing model driven by the
// bench's own view of the line, compared every cycle, plus hand-computed pins.
module tb_receptor_serie_4b;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx;
  logic [3:0] Q;
  logic       valid;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  receptor_serie_4b #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .rx    (rx),
    .Q     (Q),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the line as seen two edges late; frame events at fixed offsets from
  // the edge E where an enabled idle receiver first sees a low line.
  logic       h1, h2, rs;
  bit         active;
  int         off;
  logic [3:0] bits;
  logic [3:0] exp_q;
  logic       exp_valid, exp_err, exp_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 = 1'b1; h2 = 1'b1;
      active = 1'b0; off = 0; bits = '0;
      exp_q = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
    end else begin
      rs = h2; h2 = h1; h1 = rx;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (!active) begin
        if (en && !rs) begin
          active = 1'b1;
          off = 0;
        end
      end else begin
        off++;
        if (off == DIV / 2 && rs) active = 1'b0;
        for (int k = 0; k < 4; k++)
          if (off == DIV / 2 + DIV * (k + 1)) bits[k] = rs;
        if (off == DIV / 2 + 5 * DIV) begin
          active = 1'b0;
          if (rs) begin
            exp_q = bits;
            exp_valid = 1'b1;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
      exp_busy = active;
    end
  end

  // Downstream 4-bit register fed by the receiver.
  logic [3:0] dreg;
  always @(posedge clk or negedge rst) begin
    if (!rst) dreg <= '0;
    else if (valid) dreg <= Q;
  end

  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         busy_cyc = 0;
  int         last_valid_cyc = 0;
  logic [3:0] q_log[$];

  always @(negedge clk) begin
    if (rst) begin
      check("valid", {3'b0, valid}, {3'b0, exp_valid});
      check("err",   {3'b0, err},   {3'b0, exp_err});
      check("busy",  {3'b0, busy},  {3'b0, exp_busy});
      check("Q",     Q,             exp_q);
      if (valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        q_log.push_back(Q);
      end
      if (err)  err_cnt++;
      if (busy) busy_cyc++;
    end
  end

  int fall_edge;
  int vb, eb, bb;

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    vb = valid_cnt; eb = err_cnt; bb = busy_cyc;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop_bit, input logic drop_en);
    fall_edge = cyc + 1;
    drive_bit(1'b0);
    if (drop_en) en = 1'b0;
    for (int k = 0; k < 4; k++) drive_bit(d[k]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rx = 1'b1; en = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state while held in reset.
    repeat (3) @(negedge clk);
    #1;
    check("rst_Q", Q, 4'b0000);
    check("rst_valid", {3'b0, valid}, 4'b0);
    check("rst_err", {3'b0, err}, 4'b0);
    check("rst_busy", {3'b0, busy}, 4'b0);
    rst = 1'b1;
    en  = 1'b1;
    snap();
    idle_wait(50);
    check_int("quiet_valid", valid_cnt - vb, 0);
    check_int("quiet_err", err_cnt - eb, 0);
    check_int("quiet_busy", busy_cyc - bb, 0);

    // Single frame: bits 1,1,0,1.
    snap();
    send_frame(4'b1011, 1'b1, 1'b0);
    idle_wait(6);
    check("single_Q", Q, 4'b1011);
    check_int("single_valid", valid_cnt - vb, 1);
    check_int("single_err", err_cnt - eb, 0);
    check_int("latency", last_valid_cyc - fall_edge, 24);

    // Framing error: bits 0,1,0,1 with a low stop bit.
    snap();
    send_frame(4'b1010, 1'b0, 1'b0);
    idle_wait(8);
    check_int("frame_err", err_cnt - eb, 1);
    check_int("frame_valid", valid_cnt - vb, 0);
    check("frame_Q", Q, 4'b1011);

    // One-cycle glitch.
    snap();
    rx = 1'b0;
    @(negedge clk);
    #1 rx = 1'b1;
    idle_wait(12);
    check_int("glitch_busy", busy_cyc - bb, DIV / 2);
    check_int("glitch_valid", valid_cnt - vb, 0);
    check_int("glitch_err", err_cnt - eb, 0);
    check("glitch_Q", Q, 4'b1011);

    // Back-to-back frames.
    snap();
    send_frame(4'b1011, 1'b1, 1'b0);
    send_frame(4'b0011, 1'b1, 1'b0);
    idle_wait(6);
    check_int("b2b_valid", valid_cnt - vb, 2);
    if (q_log.size() >= 2) begin
      check("b2b_Q1", q_log[q_log.size()-2], 4'b1011);
      check("b2b_Q2", q_log[q_log.size()-1], 4'b0011);
    end else begin
      check_int("b2b_log", q_log.size(), 2);
    end
    check("b2b_dreg", dreg, 4'b0011);

    // Line stuck low: repeated framing errors, no lockup.
    snap();
    rx = 1'b0;
    repeat (70) @(negedge clk);
    rx = 1'b1;
    idle_wait(40);
    check_int("stuck_err", err_cnt - eb, 3);
    check_int("stuck_valid", valid_cnt - vb, 0);
    check("stuck_Q", Q, 4'b0011);

    // Reset during data bit 2, then a clean 0110 frame.
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    @(negedge clk);
    #1 check("mid_busy", {3'b0, busy}, 4'b0001);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_Q", Q, 4'b0000);
    check("mid_rst_busy", {3'b0, busy}, 4'b0);
    check("mid_rst_valid", {3'b0, valid | err}, 4'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_wait(5);
    send_frame(4'b0110, 1'b1, 1'b0);
    idle_wait(6);
    check("after_rst_Q", Q, 4'b0110);

    // Enable dropped mid-frame: frame still completes.
    snap();
    send_frame(4'b1001, 1'b1, 1'b1);
    idle_wait(6);
    check("drop_en_Q", Q, 4'b1001);
    check_int("drop_en_valid", valid_cnt - vb, 1);

    // Receiver disabled: full frame ignored.
    snap();
    send_frame(4'b0101, 1'b1, 1'b0);
    idle_wait(6);
    check_int("dis_busy", busy_cyc - bb, 0);
    check_int("dis_valid", valid_cnt - vb, 0);
    check("dis_Q", Q, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
